// File: rtl/cascade_mod_counter.sv
// ---------------------------------------------------------------------------
// cascade_mod_counter
//
// Two-stage cascaded modulo counter on a single clock. The low digit counts
// modulo LO_MOD and carries (or borrows) into the high digit, which counts
// modulo HI_MOD. Stepping is gated by a count-enable strobe, so there is no
// rippled clock.
//
// Optional feature macro: COUNTER_DOWN_EN
//   defined   -> i_dir selects up (0) or down (1) counting, with down
//                terminal detection.
//   undefined -> up-only counter; i_dir is ignored.
//
// Parameters
//   LO_MOD, HI_MOD : stage moduli (>= 2)
//   LO_W, HI_W     : stage widths (2**W >= MOD)
//
// Ports
//   i_clk      : sole clock, rising edge
//   i_rst_n    : synchronous active-low reset
//   i_en       : count strobe, one step per cycle high
//   i_load     : synchronous load of i_lo_val / i_hi_val (clamped to MOD-1)
//   i_lo_val   : low-stage load value
//   i_hi_val   : high-stage load value
//   i_sat      : 1 = saturate at terminal, 0 = wrap
//   i_dir      : 0 = up, 1 = down (honoured only with COUNTER_DOWN_EN)
//   o_lo, o_hi : registered stage states
//   o_lo_wrap  : registered one-cycle pulse, low stage wrapped/borrowed
//   o_wrap     : registered one-cycle pulse, whole counter wrapped
//   o_tc       : level, counter sits at the terminal value for i_dir
// ---------------------------------------------------------------------------
module cascade_mod_counter #(
  parameter int LO_MOD = 10,
  parameter int HI_MOD = 6,
  parameter int LO_W   = 4,
  parameter int HI_W   = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_load,
  input  logic [LO_W-1:0] i_lo_val,
  input  logic [HI_W-1:0] i_hi_val,
  input  logic            i_sat,
  input  logic            i_dir,
  output logic [LO_W-1:0] o_lo,
  output logic [HI_W-1:0] o_hi,
  output logic            o_lo_wrap,
  output logic            o_wrap,
  output logic            o_tc
);

  localparam logic [LO_W-1:0] LO_MAX = LO_W'(LO_MOD - 1);
  localparam logic [HI_W-1:0] HI_MAX = HI_W'(HI_MOD - 1);

  logic [LO_W-1:0] lo_q, lo_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic            lo_wrap_q, lo_wrap_d;
  logic            wrap_q, wrap_d;
  logic            tc;

  // Terminal detection from registered state and the live direction input.
`ifdef COUNTER_DOWN_EN
  always_comb begin
    if (i_dir) tc = (lo_q == '0) && (hi_q == '0);
    else       tc = (lo_q == LO_MAX) && (hi_q == HI_MAX);
  end
`else
  // Up-only build: direction input has no function.
  logic unused_dir;
  assign unused_dir = i_dir;
  assign tc = (lo_q == LO_MAX) && (hi_q == HI_MAX);
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    lo_d      = lo_q;
    hi_d      = hi_q;
    lo_wrap_d = 1'b0;
    wrap_d    = 1'b0;

    if (i_load) begin
      // Clamp so out-of-range digit values can never be loaded.
      lo_d = (i_lo_val > LO_MAX) ? LO_MAX : i_lo_val;
      hi_d = (i_hi_val > HI_MAX) ? HI_MAX : i_hi_val;
    end else if (i_en && !(i_sat && tc)) begin
`ifdef COUNTER_DOWN_EN
      if (i_dir) begin
        if (lo_q == '0) begin
          lo_d      = LO_MAX;
          lo_wrap_d = 1'b1;
          if (hi_q == '0) begin
            hi_d   = HI_MAX;
            wrap_d = 1'b1;
          end else begin
            hi_d = hi_q - HI_W'(1);
          end
        end else begin
          lo_d = lo_q - LO_W'(1);
        end
      end else
`endif
      begin
        if (lo_q == LO_MAX) begin
          lo_d      = '0;
          lo_wrap_d = 1'b1;
          if (hi_q == HI_MAX) begin
            hi_d   = '0;
            wrap_d = 1'b1;
          end else begin
            hi_d = hi_q + HI_W'(1);
          end
        end else begin
          lo_d = lo_q + LO_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lo_q      <= '0;
      hi_q      <= '0;
      lo_wrap_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      lo_wrap_q <= lo_wrap_d;
      wrap_q    <= wrap_d;
    end
  end

  assign o_lo      = lo_q;
  assign o_hi      = hi_q;
  assign o_lo_wrap = lo_wrap_q;
  assign o_wrap    = wrap_q;
  assign o_tc      = tc;

endmodule
